vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Pixel-timing master for the Pong display path. Generates 640x480@60 Hz VGA sync, the raster counters, and the 6-bit tile coordinates (`h_pos`, `v_pos`) that object controllers such as the ball and paddle blocks compare against. It collects their `disp_*` hit flags and drives the final blanked, registered RGB pixel. It sits between the object controllers and the board VGA pins.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `BALL_COLOR`, 12'hFFF: ball RGB444
- `PADDLE_COLOR`, 12'h0F0: paddle RGB444
- `BG_COLOR`, 12'h000: background RGB444

Ports:
- `clk_in`  in  1: system clock
- `reset`  in  1: **synchronous, active-high** reset; one clock only
- `disp_ball`  in  1: ball hit flag, registered one pix_tick after `h_pos`/`v_pos`
- `disp_paddle`  in  1: paddle hit flag, same timing as `disp_ball`
- `pix_tick`  out  1: pixel-enable strobe
- `h_cnt`  out  10: horizontal counter, 0..799
- `v_cnt`  out  10: vertical counter, 0..524
- `h_pos`  out  6: tile column, `h_cnt[9:4]`
- `v_pos`  out  6: tile row, `v_cnt[9:4]`
- `hsync`  out  1: active-low hsync, pipeline-aligned with `rgb`
- `vsync`  out  1: active-low vsync, pipeline-aligned with `rgb`
- `video_on`  out  1: active-area flag, aligned with `rgb`
- `frame_tick`  out  1: one-clock pulse at each frame start
- `rgb`  out  12: pixel colour, 0 when blanked

## Operation
- **Counters.** Both advance only on `pix_tick`.
  - `h_cnt` wraps 799 -> 0.
  - `v_cnt` increments when `h_cnt` wraps, and wraps 524 -> 0.
  - `h_pos` and `v_pos` are the upper counter bits, so they are combinationally consistent with the counters and have zero latency.
- **Horizontal phase FSM.** States ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - Transitions fire at `h_cnt` = 639, 655, 751, 799, on `pix_tick`.
  - hsync_raw = 0 only in SYNC.
- **Vertical phase FSM.** Same four states, advancing only at line end.
  - Boundaries are `v_cnt` = 479, 489, 491, 524.
  - vsync_raw = 0 only in SYNC.
- **Active flag.** active_raw = horizontal ACTIVE AND vertical ACTIVE.
- **Pixel colour stage.** Registered on `pix_tick`:
  - !active_d1 -> 0
  - else `disp_ball` -> `BALL_COLOR`
  - else `disp_paddle` -> `PADDLE_COLOR`
  - else `BG_COLOR`
  - Ball has priority over paddle.
- **Output alignment.** hsync_raw, vsync_raw and active_raw pass through a 2-stage pix_tick-enabled delay. This matches the path counter -> object controller register -> rgb register, so `hsync`, `vsync`, `video_on` and `rgb` describe the same pixel.
- **`frame_tick`.** High for exactly one `clk_in` cycle, the cycle after the `pix_tick` that moves the counters from (799, 524) to (0, 0).
- **Reset values.**
  - Counters 0, both FSMs in ACTIVE, delay stages cleared to inactive.
  - `hsync` = 1, `vsync` = 1, `video_on` = 0, `rgb` = 0, `frame_tick` = 0.
  - The `pix_tick` divider is cleared to 0.
- **Reset mid-line.** All of the above are applied on the next clock. There is no partial-frame recovery; the raster restarts at (0, 0).

## Timing
- Line: 800 pix_ticks. Frame: 525 lines = 420000 pix_ticks.
- `rgb`, `hsync`, `vsync` and `video_on` lag `h_cnt`/`v_cnt` by exactly 2 pix_ticks.
- `h_pos`/`v_pos` -> `disp_*` is expected at exactly 1 pix_tick. Any other latency in an object controller is a misalignment, not a bug in this block.
- `pix_tick` is a single-cycle enable with no handshake. Upstream blocks sample `h_pos`/`v_pos` on `pix_tick`.

## Configuration
- `PIX_DIV2_EN`
  - **Defined:** `pix_tick` toggles every `clk_in` (high on alternate cycles, first high on the 2nd cycle after reset). Supports a 50 MHz board clock, giving a 25 MHz pixel rate.
  - **Undefined:** `pix_tick` is held at 1 and the block runs one pixel per `clk_in`, for a 25 MHz clock.

## Test plan
- **Reset.** Assert `reset` for 1 cycle mid-frame at `h_cnt` = 300, `v_cnt` = 200.
  -> Next cycle: counters 0, `hsync` = `vsync` = 1, `video_on` = 0, `rgb` = 0, `frame_tick` = 0.
- **Line timing.** Free-run one line.
  -> `hsync` low for exactly 96 pix_ticks, first low at counter `h_cnt` = 656 + 2 ticks.
  -> `video_on` high for 640 ticks per visible line.
- **Frame timing.** Free-run 2 frames.
  -> `vsync` low for 1600 pix_ticks (lines 490–491).
  -> `frame_tick` pulses exactly 420000 pix_ticks apart, each 1 `clk_in` wide.
- **Ball window.** Model a ball controller returning `disp_ball` = 1 when (`h_pos`, `v_pos`) = (20, 15), with 1-tick latency.
  -> `rgb` = FFF for exactly pixels x 320..335, y 240..255, and 000 elsewhere in the active area.
- **Priority and blanking.** Hold `disp_ball` = `disp_paddle` = 1 constantly.
  -> `rgb` = FFF whenever `video_on` = 1, and 000 whenever `video_on` = 0.
  -> Ball-only gives FFF; paddle-only gives 0F0.
- **Divider.** With `PIX_DIV2_EN` defined:
  -> `pix_tick` duty is 50%.
  -> Line length is 1600 `clk_in` cycles.
  -> Counters hold their value between ticks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA raster timing master for the Pong display.
// Produces the pixel-enable strobe, raster counters, 6-bit tile coordinates,
// sync/blank pulses delayed to line up with the registered RGB pixel, and a
// one-clock frame-start pulse.
// Build option: define PIX_DIV2_EN to derive pix_tick from clk_in / 2
// (50 MHz board clock); leave it undefined to run one pixel per clk_in.
module vga_sync_gen #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter logic [11:0] BALL_COLOR   = 12'hFFF,
    parameter logic [11:0] PADDLE_COLOR = 12'h0F0,
    parameter logic [11:0] BG_COLOR     = 12'h000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        disp_ball,
    input  logic        disp_paddle,
    output logic        pix_tick,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic [5:0]  h_pos,
    output logic [5:0]  v_pos,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_tick,
    output logic [11:0] rgb
);

    // Last counter value of each phase; the FSMs leave a phase on these.
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    logic       w_pix_tick;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_line_end;
    logic       w_active_p0;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    phase_t     r_h_state;
    phase_t     r_v_state;
    logic       r_hsync_p0;
    logic       r_vsync_p0;
    logic       r_h_act_p0;
    logic       r_v_act_p0;
    logic       r_hsync_p1;
    logic       r_vsync_p1;
    logic       r_active_p1;
    logic       r_hsync_p2;
    logic       r_vsync_p2;
    logic       r_active_p2;
    logic [11:0] r_rgb_p2;
    logic       r_frame_tick;

    // Blanking wins, then ball over paddle, then background.
    function automatic logic [11:0] pick_color(input logic act,
                                               input logic ball,
                                               input logic paddle);
        if (!act)
            return 12'h000;
        else if (ball)
            return BALL_COLOR;
        else if (paddle)
            return PADDLE_COLOR;
        else
            return BG_COLOR;
    endfunction

`ifdef PIX_DIV2_EN
    logic r_div;

    // Divide-by-two pixel enable; low on the first cycle after reset.
    always_ff @(posedge clk_in) begin
        if (reset)
            r_div <= 1'b0;
        else
            r_div <= ~r_div;
    end

    assign w_pix_tick = r_div;
`else
    assign w_pix_tick = 1'b1;
`endif

    assign w_h_last   = (r_h_cnt == H_LAST);
    assign w_v_last   = (r_v_cnt == V_LAST);
    assign w_line_end = w_pix_tick && w_h_last;

    // Raster counters: h wraps at line end, v steps on h wrap and wraps at frame end.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_pix_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                if (w_v_last)
                    r_v_cnt <= '0;
                else
                    r_v_cnt <= r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Horizontal phase FSM; sync/active flags are registered with the state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_h_state  <= PH_ACTIVE;
            r_hsync_p0 <= 1'b1;
            r_h_act_p0 <= 1'b1;
        end else if (w_pix_tick) begin
            case (r_h_state)
                PH_ACTIVE: if (r_h_cnt == H_ACT_END) begin
                    r_h_state  <= PH_FP;
                    r_h_act_p0 <= 1'b0;
                end
                PH_FP: if (r_h_cnt == H_FP_END) begin
                    r_h_state  <= PH_SYNC;
                    r_hsync_p0 <= 1'b0;
                end
                PH_SYNC: if (r_h_cnt == H_SYNC_END) begin
                    r_h_state  <= PH_BP;
                    r_hsync_p0 <= 1'b1;
                end
                PH_BP: if (r_h_cnt == H_LAST) begin
                    r_h_state  <= PH_ACTIVE;
                    r_h_act_p0 <= 1'b1;
                end
                default: begin
                    r_h_state  <= PH_ACTIVE;
                    r_hsync_p0 <= 1'b1;
                    r_h_act_p0 <= 1'b1;
                end
            endcase
        end
    end

    // Vertical phase FSM; advances only on the last pixel of a line.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_v_state  <= PH_ACTIVE;
            r_vsync_p0 <= 1'b1;
            r_v_act_p0 <= 1'b1;
        end else if (w_line_end) begin
            case (r_v_state)
                PH_ACTIVE: if (r_v_cnt == V_ACT_END) begin
                    r_v_state  <= PH_FP;
                    r_v_act_p0 <= 1'b0;
                end
                PH_FP: if (r_v_cnt == V_FP_END) begin
                    r_v_state  <= PH_SYNC;
                    r_vsync_p0 <= 1'b0;
                end
                PH_SYNC: if (r_v_cnt == V_SYNC_END) begin
                    r_v_state  <= PH_BP;
                    r_vsync_p0 <= 1'b1;
                end
                PH_BP: if (r_v_cnt == V_LAST) begin
                    r_v_state  <= PH_ACTIVE;
                    r_v_act_p0 <= 1'b1;
                end
                default: begin
                    r_v_state  <= PH_ACTIVE;
                    r_vsync_p0 <= 1'b1;
                    r_v_act_p0 <= 1'b1;
                end
            endcase
        end
    end

    assign w_active_p0 = r_h_act_p0 && r_v_act_p0;

    // Stage p0 -> p1: matches the object controllers' registered hit flags.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_hsync_p1  <= 1'b1;
            r_vsync_p1  <= 1'b1;
            r_active_p1 <= 1'b0;
        end else if (w_pix_tick) begin
            r_hsync_p1  <= r_hsync_p0;
            r_vsync_p1  <= r_vsync_p0;
            r_active_p1 <= w_active_p0;
        end
    end

    // Stage p1 -> p2: sync/blank delayed to sit beside the registered pixel.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_hsync_p2  <= 1'b1;
            r_vsync_p2  <= 1'b1;
            r_active_p2 <= 1'b0;
        end else if (w_pix_tick) begin
            r_hsync_p2  <= r_hsync_p1;
            r_vsync_p2  <= r_vsync_p1;
            r_active_p2 <= r_active_p1;
        end
    end

    // Pixel colour register, stage p1 -> p2, using the hit flags for this pixel.
    always_ff @(posedge clk_in) begin
        if (reset)
            r_rgb_p2 <= 12'h000;
        else if (w_pix_tick)
            r_rgb_p2 <= pick_color(r_active_p1, disp_ball, disp_paddle);
    end

    // Frame-start pulse: the clock after the counters wrap from the last pixel.
    always_ff @(posedge clk_in) begin
        if (reset)
            r_frame_tick <= 1'b0;
        else
            r_frame_tick <= w_line_end && w_v_last;
    end

    assign pix_tick   = w_pix_tick;
    assign h_cnt      = r_h_cnt;
    assign v_cnt      = r_v_cnt;
    assign h_pos      = r_h_cnt[9:4];
    assign v_pos      = r_v_cnt[9:4];
    assign hsync      = r_hsync_p2;
    assign vsync      = r_vsync_p2;
    assign video_on   = r_active_p2;
    assign rgb        = r_rgb_p2;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Horizontal timing is the full 800-pixel line;
// the frame is shortened to 36 lines (32 visible) so two whole frames fit in
// a short run. The ball window therefore sits at tile (20,1): x 320..335,
// y 16..31. Frame 0 exercises the ball window, frame 1 exercises priority
// (tile row 0: both flags high) and single flags (tile row 1: ball-only left
// of x=320, paddle-only from x=320).
module tb_vga_sync_gen;

    localparam int H_ACT = 640;
    localparam int H_FPW = 16;
    localparam int H_SYW = 96;
    localparam int H_BPW = 48;
    localparam int V_ACT = 32;
    localparam int V_FPW = 1;
    localparam int V_SYW = 2;
    localparam int V_BPW = 1;
    localparam int H_TOT = H_ACT + H_FPW + H_SYW + H_BPW;
    localparam int V_TOT = V_ACT + V_FPW + V_SYW + V_BPW;
`ifdef PIX_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int EXP_HS_LOW   = 96;
    localparam int EXP_HS_FIRST = 658;
    localparam int EXP_VO_RUN   = 640;
    localparam int EXP_VS_LOW   = 1600;
    localparam int EXP_FRAME    = 28800;
    localparam int EXP_LINE_CLK = 800 * DIV;
    localparam int CYC_LIMIT    = 62000 * DIV;

    logic        clk;
    logic        reset;
    logic        disp_ball;
    logic        disp_paddle;
    logic        pix_tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [5:0]  h_pos;
    logic [5:0]  v_pos;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_tick;
    logic [11:0] rgb;

    vga_sync_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FPW), .H_SYNC(H_SYW), .H_BP(H_BPW),
        .V_ACTIVE(V_ACT), .V_FP(V_FPW), .V_SYNC(V_SYW), .V_BP(V_BPW),
        .BALL_COLOR(12'hFFF), .PADDLE_COLOR(12'h0F0), .BG_COLOR(12'h000)
    ) dut (
        .clk_in(clk), .reset(reset), .disp_ball(disp_ball), .disp_paddle(disp_paddle),
        .pix_tick(pix_tick), .h_cnt(h_cnt), .v_cnt(v_cnt), .h_pos(h_pos), .v_pos(v_pos),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_tick(frame_tick),
        .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [14:0] sb_q[$];
    logic run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Object-controller stand-in: hit flags for a tile in a given frame.
    function automatic logic [1:0] ctl(input int tx, input int ty, input int f);
        logic b;
        logic p;
        b = 1'b0;
        p = 1'b0;
        if (f == 0) begin
            b = (tx == 20) && (ty == 1);
        end else if (f == 1) begin
            if (ty == 0) begin
                b = 1'b1;
                p = 1'b1;
            end else if (ty == 1) begin
                b = (tx < 20);
                p = (tx >= 20);
            end
        end
        return {b, p};
    endfunction

    // Expected {hsync, vsync, video_on, rgb} for raster position (h, v).
    function automatic logic [14:0] pix_exp(input int h, input int v, input int f);
        logic        hs;
        logic        vs;
        logic        vis;
        logic [1:0]  bp;
        logic [11:0] c;
        vis = (h < H_ACT) && (v < V_ACT);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v >= V_ACT + V_FPW) && (v < V_ACT + V_FPW + V_SYW));
        bp  = ctl(h / 16, v / 16, f);
        if (!vis)
            c = 12'h000;
        else if (bp[1])
            c = 12'hFFF;
        else if (bp[0])
            c = 12'h0F0;
        else
            c = 12'h000;
        return {hs, vs, vis, c};
    endfunction

    // Monitor: pops the scoreboard on every pixel and measures pulse widths.
    int tick_cnt = 0;
    int clk_cnt = 0;
    int hs_run = 0;
    int vo_run = 0;
    int vs_run = 0;
    int last_ft_tick = 0;
    int last_hs_clk = 0;
    bit ft_seen = 0;
    bit hs_seen = 0;
    logic prev_hs = 1'b1;
    logic prev_vo = 1'b0;
    logic prev_vs = 1'b1;
    logic [14:0] exp_pix;

    always @(negedge clk) begin
        if (run) begin
            clk_cnt++;
            if (frame_tick) begin
                if (ft_seen)
                    check("frame_spacing", 32'(tick_cnt - last_ft_tick), EXP_FRAME);
                ft_seen = 1;
                last_ft_tick = tick_cnt;
            end
            if (pix_tick) begin
                tick_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_underflow: got empty queue, expected an entry");
                end else begin
                    exp_pix = sb_q.pop_front();
                    check("pixel", {17'd0, hsync, vsync, video_on, rgb}, {17'd0, exp_pix});
                end
                if (!hsync) hs_run++;
                if (prev_hs && !hsync) begin
                    if (!hs_seen)
                        check("hs_first_h", {22'd0, h_cnt}, EXP_HS_FIRST);
                    else
                        check("line_clks", 32'(clk_cnt - last_hs_clk), EXP_LINE_CLK);
                    hs_seen = 1;
                    last_hs_clk = clk_cnt;
                end
                if (!prev_hs && hsync) begin
                    check("hs_low_len", hs_run, EXP_HS_LOW);
                    hs_run = 0;
                end
                if (video_on) vo_run++;
                if (prev_vo && !video_on) begin
                    check("vo_run_len", vo_run, EXP_VO_RUN);
                    vo_run = 0;
                end
                if (!vsync) vs_run++;
                if (!prev_vs && vsync) begin
                    check("vs_low_len", vs_run, EXP_VS_LOW);
                    vs_run = 0;
                end
                prev_hs = hsync;
                prev_vo = video_on;
                prev_vs = vsync;
            end
        end
    end

    // Stimulus / model: reset tests, then free-run two frames feeding the scoreboard.
    logic [9:0] mh;
    logic [9:0] mv;
    int         mf;
    logic       exp_ft;
    logic       tick;
    logic [1:0] nxt;
    int         cyc;
    bit         found;

    initial begin
        reset = 1'b1;
        disp_ball = 1'b0;
        disp_paddle = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        disp_ball = 1'b1;

        found = 0;
        for (int i = 0; i < 4000 * DIV && !found; i++) begin
            @(negedge clk);
            if (h_cnt == 10'd300 && v_cnt == 10'd2) found = 1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reach_mid_frame: got h=%0d v=%0d, expected h=300 v=2", h_cnt, v_cnt);
        end
        check("pre_rst_video_on", {31'd0, video_on}, 32'd1);
        check("pre_rst_rgb", {20'd0, rgb}, 32'hFFF);

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        disp_ball = 1'b0;
        check("rst_counters", {12'd0, h_cnt, v_cnt}, 32'd0);
        check("rst_hsync", {31'd0, hsync}, 32'd1);
        check("rst_vsync", {31'd0, vsync}, 32'd1);
        check("rst_video_on", {31'd0, video_on}, 32'd0);
        check("rst_rgb", {20'd0, rgb}, 32'd0);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);

        sb_q.delete();
        sb_q.push_back({1'b1, 1'b1, 1'b0, 12'h000});
        sb_q.push_back({1'b1, 1'b1, 1'b0, 12'h000});
        mh = '0;
        mv = '0;
        mf = 0;
        exp_ft = 1'b0;
        nxt = 2'b00;
        cyc = 0;
        run = 1'b1;

        while ((mf < 2 || mh < 10'd4) && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
            check("counters", {h_cnt, v_cnt, h_pos, v_pos}, {mh, mv, mh[9:4], mv[9:4]});
            tick = pix_tick;
            exp_ft = tick && (mh == 10'(H_TOT - 1)) && (mv == 10'(V_TOT - 1));
            if (tick) begin
                nxt = ctl(int'(h_pos), int'(v_pos), mf);
                sb_q.push_back(pix_exp(int'(mh), int'(mv), mf));
                if (mh == 10'(H_TOT - 1)) begin
                    mh = '0;
                    if (mv == 10'(V_TOT - 1)) begin
                        mv = '0;
                        mf++;
                    end else begin
                        mv = mv + 10'd1;
                    end
                end else begin
                    mh = mh + 10'd1;
                end
            end
            @(posedge clk);
            #1;
            if (tick) begin
                disp_ball = nxt[1];
                disp_paddle = nxt[0];
            end
        end
        if (cyc >= CYC_LIMIT) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_budget: got %0d frames in %0d cycles, expected 2", mf, cyc);
        end
        run = 1'b0;
        @(negedge clk);
`ifdef PIX_DIV2_EN
        check("tick_duty", clk_cnt, 2 * tick_cnt);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
